// File: rtl/perf_monitor_ctrl.sv
// Performance monitor: counts datapath events over a start/finish window, then
// derives cycles-per-instruction with a bit-serial restoring divider.
module perf_monitor_ctrl #(
    parameter int CNT_W = 19
) (
    input  logic             clkFPGA,
    input  logic             rst,
    input  logic             start,
    input  logic             clr,
    input  logic             finish,
    input  logic             retire,
    input  logic             stall_ev,
    input  logic             alu_ev,
    input  logic             mem_ev,
    input  logic             rd_req,
    input  logic [1:0]       rd_sel,
    output logic             rd_ack,
    output logic [CNT_W-1:0] rd_data,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] alu_count,
    output logic [CNT_W-1:0] mem_count,
    output logic [CNT_W-1:0] cpi,
    output logic             busy,
    output logic             done
);

    localparam int DCW = $clog2(CNT_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            sat_inc = v;
        end
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d;
    logic [CNT_W-1:0] stall_q, stall_d, alu_q, alu_d, mem_q, mem_d;
    logic [CNT_W-1:0] dvd_q, dvd_d, rem_q, rem_d, quo_q, quo_d;
    logic [DCW-1:0]   div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] cpi_q, cpi_d, rd_data_q, rd_data_d;
    logic             busy_q, busy_d, done_q, done_d, rd_ack_q;
    logic             clear_s, fits_s;
    logic [CNT_W:0]   trial_s, diff_s;

    // One restoring-division step; a zero divisor always "fits", giving an all-ones quotient.
    always_comb begin
        trial_s = {rem_q, dvd_q[CNT_W-1]};
        diff_s  = trial_s - {1'b0, ret_q};
        fits_s  = (trial_s >= {1'b0, ret_q});
    end

    // Clear on clr in any state, and on the start edge out of IDLE/DONE.
    always_comb begin
        clear_s = clr || (start && ((state_q == IDLE) || (state_q == DONE)));
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                end else if (clr) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                if (clr) begin
                    state_d = RUN;
                end else if (finish) begin
                    state_d = DIV;
                end else begin
                    state_d = RUN;
                end
            end
            DIV: begin
                if (clr) begin
                    state_d = IDLE;
                end else if (div_cnt_q == DCW'(CNT_W - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = DIV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter and divider datapath.
    always_comb begin
        cyc_d     = cyc_q;
        ret_d     = ret_q;
        stall_d   = stall_q;
        alu_d     = alu_q;
        mem_d     = mem_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_cnt_d = div_cnt_q;
        if (clear_s) begin
            cyc_d     = {CNT_W{1'b0}};
            ret_d     = {CNT_W{1'b0}};
            stall_d   = {CNT_W{1'b0}};
            alu_d     = {CNT_W{1'b0}};
            mem_d     = {CNT_W{1'b0}};
            dvd_d     = {CNT_W{1'b0}};
            rem_d     = {CNT_W{1'b0}};
            quo_d     = {CNT_W{1'b0}};
            div_cnt_d = {DCW{1'b0}};
        end else begin
            case (state_q)
                RUN: begin
                    cyc_d   = sat_inc(cyc_q, 1'b1);
                    ret_d   = sat_inc(ret_q, retire);
                    stall_d = sat_inc(stall_q, stall_ev);
                    alu_d   = sat_inc(alu_q, alu_ev);
                    mem_d   = sat_inc(mem_q, mem_ev);
                    // The finish cycle still counts, so the dividend is the updated cycle count.
                    if (finish) begin
                        dvd_d     = cyc_d;
                        div_cnt_d = {DCW{1'b0}};
                    end else begin
                        dvd_d = dvd_q;
                    end
                end
                DIV: begin
                    dvd_d     = {dvd_q[CNT_W-2:0], 1'b0};
                    rem_d     = fits_s ? diff_s[CNT_W-1:0] : trial_s[CNT_W-1:0];
                    quo_d     = {quo_q[CNT_W-2:0], fits_s};
                    div_cnt_d = div_cnt_q + DCW'(1);
                end
                default: begin
                    cyc_d = cyc_q;
                end
            endcase
        end
    end

    // Registered status, result and read-response values.
    always_comb begin
        busy_d = (state_d == RUN) || (state_d == DIV);
        done_d = (state_q == DONE) && (state_d == DONE);
        cpi_d  = done_d ? quo_q : {CNT_W{1'b0}};
        if (rd_req) begin
            case (rd_sel)
                2'd0:    rd_data_d = stall_q;
                2'd1:    rd_data_d = alu_q;
                2'd2:    rd_data_d = mem_q;
                default: rd_data_d = cpi_q;
            endcase
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clkFPGA or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cyc_q     <= {CNT_W{1'b0}};
            ret_q     <= {CNT_W{1'b0}};
            stall_q   <= {CNT_W{1'b0}};
            alu_q     <= {CNT_W{1'b0}};
            mem_q     <= {CNT_W{1'b0}};
            dvd_q     <= {CNT_W{1'b0}};
            rem_q     <= {CNT_W{1'b0}};
            quo_q     <= {CNT_W{1'b0}};
            div_cnt_q <= {DCW{1'b0}};
            cpi_q     <= {CNT_W{1'b0}};
            rd_data_q <= {CNT_W{1'b0}};
            rd_ack_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            ret_q     <= ret_d;
            stall_q   <= stall_d;
            alu_q     <= alu_d;
            mem_q     <= mem_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_cnt_q <= div_cnt_d;
            cpi_q     <= cpi_d;
            rd_data_q <= rd_data_d;
            rd_ack_q  <= rd_req;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign stall_count = stall_q;
    assign alu_count   = alu_q;
    assign mem_count   = mem_q;
    assign cpi         = cpi_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign rd_ack      = rd_ack_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_perf_monitor_ctrl.sv
// Directed bench for perf_monitor_ctrl: default-width instance plus a CNT_W=4 instance
// sharing stimulus for saturation; read responses checked through a scoreboard queue.
module tb_perf_monitor_ctrl;
    localparam int W = 19;

    logic clkFPGA = 1'b0;
    logic rst = 1'b0, start = 1'b0, clr = 1'b0, finish = 1'b0;
    logic retire = 1'b0, stall_ev = 1'b0, alu_ev = 1'b0, mem_ev = 1'b0;
    logic rd_req = 1'b0;
    logic [1:0] rd_sel = 2'd0;

    logic         rd_ack, busy, done;
    logic [W-1:0] rd_data, stall_count, alu_count, mem_count, cpi;
    logic         rd_ack4, busy4, done4;
    logic [3:0]   rd_data4, stall4, alu4, mem4, cpi4;

    int nchk = 0, nfail = 0, reads = 0, acks = 0;
    logic [W-1:0] exp_q[$];
    logic req_s = 1'b0;

    perf_monitor_ctrl #(.CNT_W(W)) dut (
        .clkFPGA(clkFPGA), .rst(rst), .start(start), .clr(clr), .finish(finish),
        .retire(retire), .stall_ev(stall_ev), .alu_ev(alu_ev), .mem_ev(mem_ev),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack), .rd_data(rd_data),
        .stall_count(stall_count), .alu_count(alu_count), .mem_count(mem_count),
        .cpi(cpi), .busy(busy), .done(done));

    perf_monitor_ctrl #(.CNT_W(4)) dut4 (
        .clkFPGA(clkFPGA), .rst(rst), .start(start), .clr(clr), .finish(finish),
        .retire(retire), .stall_ev(stall_ev), .alu_ev(alu_ev), .mem_ev(mem_ev),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack4), .rd_data(rd_data4),
        .stall_count(stall4), .alu_count(alu4), .mem_count(mem4),
        .cpi(cpi4), .busy(busy4), .done(done4));

    always #5 clkFPGA = ~clkFPGA;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        nchk++;
        assert (obs === want) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clkFPGA);
        @(negedge clkFPGA);
    endtask

    task automatic push_read(input logic [1:0] sel, input logic [W-1:0] want);
        rd_req = 1'b1;
        rd_sel = sel;
        exp_q.push_back(want);
        reads++;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (done === 1'b1) begin
                edges = k;
                break;
            end
        end
    endtask

    always @(posedge clkFPGA) req_s <= rd_req;

    // Read-response monitor: ack one cycle after each request, data from the scoreboard.
    always @(negedge clkFPGA) begin
        if (rst === 1'b1) begin
            check("rd_ack_timing", 32'(rd_ack), 32'(req_s));
            if (rd_ack === 1'b1) begin
                acks++;
                if (exp_q.size() == 0) begin
                    nchk++;
                    nfail++;
                    $error("FAIL rd_ack_spurious: observed ack expected none");
                end else begin
                    check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int m_stall, m_alu, m_mem, edges, seen;
        m_stall = 0; m_alu = 0; m_mem = 0;

        // Reset state
        repeat (2) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ack", 32'(rd_ack), 32'd0);
        check("rst_rdata", 32'(rd_data), 32'd0);
        check("rst_stall", 32'(stall_count), 32'd0);
        check("rst_cpi", 32'(cpi), 32'd0);
        rst = 1'b1;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // Basic measurement: 10 RUN cycles, 4 retires
        start = 1'b1; step(); start = 1'b0;
        check("run_busy", 32'(busy), 32'd1);
        check("run_done", 32'(done), 32'd0);
        for (int i = 0; i < 10; i++) begin
            retire   = (i % 3 == 0);
            stall_ev = (i < 3);
            alu_ev   = (i % 2 == 1);
            mem_ev   = (i >= 7);
            finish   = (i == 9);
            rd_req   = 1'b0;
            if (i == 2) push_read(2'd3, '0);
            if (i == 5) push_read(2'd1, W'(m_alu));
            step();
            m_stall += int'(stall_ev);
            m_alu   += int'(alu_ev);
            m_mem   += int'(mem_ev);
        end
        {retire, stall_ev, alu_ev, mem_ev, finish, rd_req} = 6'b0;
        check("div_busy", 32'(busy), 32'd1);
        check("stall_cnt", 32'(stall_count), 32'(m_stall));
        check("alu_cnt", 32'(alu_count), 32'(m_alu));
        check("mem_cnt", 32'(mem_count), 32'(m_mem));
        wait_done(edges);
        check("done_latency", 32'(edges), 32'd20);
        check("cpi_basic", 32'(cpi), 32'd2);
        check("done_busy", 32'(busy), 32'd0);

        // Reads in DONE
        for (int s = 0; s < 4; s++) begin
            push_read(2'(s), (s == 0) ? W'(m_stall) : (s == 1) ? W'(m_alu) : (s == 2) ? W'(m_mem) : W'(2));
            step();
        end
        rd_req = 1'b0;
        repeat (2) step();
        check("rd_hold", 32'(rd_data), 32'd2);
        check("rd_no_side_done", 32'(done), 32'd1);
        check("rd_no_side_stall", 32'(stall_count), 32'(m_stall));
        check("rd_no_side_cpi", 32'(cpi), 32'd2);

        // Zero retires, restart from DONE
        start = 1'b1; step(); start = 1'b0;
        check("restart_cpi", 32'(cpi), 32'd0);
        check("restart_done", 32'(done), 32'd0);
        check("restart_stall", 32'(stall_count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            finish = (i == 4);
            step();
        end
        finish = 1'b0;
        wait_done(edges);
        check("done_latency_z", 32'(edges), 32'd20);
        check("cpi_zero_ret", 32'(cpi), 32'd524287);
        check("cpi4_zero_ret", 32'(cpi4), 32'd15);

        // clr in DONE, then events in IDLE are ignored
        clr = 1'b1; step(); clr = 1'b0;
        check("clr_done", 32'(done), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_cpi", 32'(cpi), 32'd0);
        {retire, stall_ev, alu_ev, mem_ev} = 4'hF; step(); {retire, stall_ev, alu_ev, mem_ev} = 4'h0;
        check("idle_ev_alu", 32'(alu_count), 32'd0);
        check("idle_ev_stall", 32'(stall_count), 32'd0);

        // Clear precedence in RUN; start ignored in RUN
        start = 1'b1; step(); start = 1'b0;
        stall_ev = 1'b1; repeat (2) step();
        check("pre_clr_stall", 32'(stall_count), 32'd2);
        clr = 1'b1; step(); clr = 1'b0;
        check("clr_wins_stall", 32'(stall_count), 32'd0);
        check("clr_run_busy", 32'(busy), 32'd1);
        step();
        check("post_clr_stall", 32'(stall_count), 32'd1);
        stall_ev = 1'b0; start = 1'b1; step(); start = 1'b0;
        check("start_in_run", 32'(stall_count), 32'd1);

        // Saturation
        clr = 1'b1; step(); clr = 1'b0;
        alu_ev = 1'b1; repeat (20) step(); alu_ev = 1'b0;
        check("alu4_sat", 32'(alu4), 32'd15);
        check("alu_20", 32'(alu_count), 32'd20);

        // Abort during DIV
        finish = 1'b1; step(); finish = 1'b0;
        check("abort_div_busy", 32'(busy), 32'd1);
        repeat (5) step();
        clr = 1'b1; step(); clr = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cpi", 32'(cpi), 32'd0);
        check("abort_alu", 32'(alu_count), 32'd0);
        seen = 0;
        repeat (25) begin
            step();
            if (done !== 1'b0) seen = 1;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        // Asynchronous reset in RUN
        start = 1'b1; step(); start = 1'b0;
        {stall_ev, alu_ev, retire} = 3'b111; repeat (2) step(); {stall_ev, alu_ev, retire} = 3'b000;
        check("pre_rst_stall", 32'(stall_count), 32'd2);
        #2 rst = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_stall", 32'(stall_count), 32'd0);
        check("async_alu", 32'(alu_count), 32'd0);
        check("async_rdata", 32'(rd_data), 32'd0);
        @(negedge clkFPGA);
        rst = 1'b1;
        step();
        check("post_rst_idle", 32'(busy), 32'd0);
        start = 1'b1; step(); start = 1'b0;
        check("post_rst_start", 32'(busy), 32'd1);

        step();
        check("ack_count", 32'(acks), 32'(reads));
        check("rd_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/perf_monitor_ctrl.md
PERF_MONITOR_CTRL -- requirements
Module: perf_monitor_ctrl

Interface
REQ-001 Parameter CNT_W, default 19: width of every event counter, cycle counter and result.
REQ-002 clkFPGA  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous assert, active-low.
REQ-004 start  in  1  begins a measurement window; sampled in IDLE or DONE only.
REQ-005 clr  in  1  synchronous clear of all counters and result.
REQ-006 finish  in  1  datapath program-complete flag (level).
REQ-007 retire, stall_ev, alu_ev, mem_ev  in  1 each  per-cycle event strobes from the datapath.
REQ-008 rd_req  in  1; rd_sel  in  2  debug read request and counter select.
REQ-009 rd_ack  out  1; rd_data  out  CNT_W  registered read response.
REQ-010 stall_count, alu_count, mem_count, cpi  out  CNT_W each  live values for probe export.
REQ-011 busy  out  1  high in RUN or DIV; done  out  1  high in DONE.

Function
REQ-012 The block SHALL implement states IDLE, RUN, DIV, DONE, with IDLE as the reset state.
REQ-013 Transitions:
- IDLE/DONE -> RUN on start.
- RUN -> DIV on finish.
- DIV -> DONE after exactly CNT_W cycles.
- DONE -> IDLE on clr.
- All other cases hold the current state.
REQ-014 On the edge leaving IDLE/DONE for RUN, all counters and cpi SHALL load 0.
REQ-015 In RUN, cycle_cnt SHALL increment every cycle, including the cycle in which finish is sampled.
REQ-016 In RUN, each of retire, stall_ev, alu_ev and mem_ev SHALL increment its own counter in every cycle it is high, including the finish cycle.
REQ-017 Events outside RUN SHALL be ignored.
REQ-018 Every counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-019 In DIV, the block SHALL compute cpi = floor(cycle_cnt / retire_cnt) by restoring division, one quotient bit per cycle, MSB first.
REQ-020 If retire_cnt = 0, cpi SHALL be 2^CNT_W-1. DIV SHALL still last CNT_W cycles.
REQ-021 cpi SHALL read 0 outside DONE and SHALL hold the final quotient throughout DONE.
REQ-022 done SHALL rise CNT_W+1 edges after the edge that samples finish in RUN.
REQ-023 start SHALL be ignored while in RUN or DIV.
REQ-024 clr in RUN SHALL zero all counters and keep state RUN.
REQ-025 clr in DIV SHALL abort the division, zero everything and go to IDLE.
REQ-026 When clr and an event occur in the same cycle, clr SHALL win and the counter SHALL be 0 after the edge.
REQ-027 When start and clr occur in the same cycle, the block SHALL enter RUN with counters at 0.
REQ-028 rd_ack SHALL be high on the cycle after each cycle in which rd_req is sampled high, in any state.
REQ-029 rd_data SHALL carry the value selected at the request edge: 0 = stall, 1 = alu, 2 = mem, 3 = cpi.
REQ-030 rd_data SHALL hold its last value while rd_ack is low.
REQ-031 A read SHALL never alter counters or state.

Reset
REQ-032 While rst is low, the block SHALL hold state IDLE with all counters, cpi, rd_data, rd_ack, busy and done at 0, independent of clkFPGA.
REQ-033 After reset deassertion, the first active edge SHALL obey the normal IDLE rules.
REQ-034 Reset in any state mid-operation SHALL discard the measurement and any partial quotient.

Verification
REQ-035 Basic measurement: start, then 10 RUN cycles with retire high in 4 of them and finish sampled on the 10th -> stall/alu/mem per stimulus, done rises 20 edges after the finish edge, cpi = 2.
REQ-036 Zero retires: start, then 5 RUN cycles with retire low throughout, then finish -> cpi = 524287 in DONE.
REQ-037 Saturation: CNT_W = 4 build, alu_ev high for 20 RUN cycles -> alu_count holds 15 and does not wrap to 4.
REQ-038 Clear precedence: clr in RUN in the same cycle as stall_ev -> stall_count = 0 next cycle, busy stays 1.
REQ-039 Abort: clr during DIV -> next cycle IDLE, cpi = 0, done never asserts. Reset asserted in RUN -> all outputs 0 immediately without a clock edge.
REQ-040 Reads: rd_req pulses with rd_sel = 0..3 in DONE after REQ-035 -> four rd_ack pulses one cycle late with data matching the live outputs (cpi = 2); the same reads in RUN return cpi = 0.
